// File: rtl/calc_pkg.sv
// Shared command/response codes, FSM encoding and counter sizing for the calc port responder.
package calc_pkg;

    typedef enum logic [0:3] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [0:1] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [0:2] {
        IDLE = 3'd0,
        OP2  = 3'd1,
        EXEC = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam int CNT_W = 4;

    // Any code outside the four arithmetic commands is rejected without an operand2 cycle.
    function automatic logic is_valid_cmd(input logic [0:3] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/calc_port_responder_if.sv
// Request/response bundle of one calc port; the requester is the master, the responder the slave.
interface calc_port_responder_if;

    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy
    );

endinterface

// File: rtl/calc_alu.sv
// Combinational calc datapath: add/sub with overflow/underflow detection and logical shifts.
module calc_alu
    import calc_pkg::*;
(
    input  logic [0:3]  cmd_i,
    input  logic [0:31] op1_i,
    input  logic [0:31] op2_i,
    output logic [0:31] result_o,
    output logic        err_o
);

    logic [0:32] sum;

    assign sum = {1'b0, op1_i} + {1'b0, op2_i};

    // An error always reports a zero result so the top can register result_o unconditionally.
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (cmd_i)
            CMD_ADD: begin
                if (sum[0]) err_o    = 1'b1;
                else        result_o = sum[1:32];
            end
            CMD_SUB: begin
                if (op2_i > op1_i) err_o    = 1'b1;
                else               result_o = op1_i - op2_i;
            end
            CMD_SHL: result_o = op1_i << op2_i[27:31];
            CMD_SHR: result_o = op1_i >> op2_i[27:31];
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// Single-port calc responder: two-cycle request, programmable execute delay, one-cycle registered response.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input logic                  c_clk,
    input logic                  reset,
    calc_port_responder_if.slave bus
);

    localparam logic [0:CNT_W-1] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_e            state_q;
    logic [0:3]        cmd_q;
    logic [0:DATA_W-1] op1_q;
    logic [0:DATA_W-1] op2_q;
    logic [0:CNT_W-1]  cnt_q;
    logic [0:CNT_W-1]  cnt_d;
    logic [0:1]        resp_q;
    logic [0:DATA_W-1] data_q;
    logic              busy_q;
    logic [0:DATA_W-1] alu_result;
    logic              alu_err;

    calc_alu u_alu (
        .cmd_i    (cmd_q),
        .op1_i    (op1_q),
        .op2_i    (op2_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    assign cnt_d = cnt_q - CNT_W'(1);

    // Response registers default to zero every cycle and are only loaded on the edge entering RESP/ERR.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            resp_q <= RESP_NONE;
            data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.req_cmd_in != CMD_NONE) begin
                        busy_q <= 1'b1;
                        if (is_valid_cmd(bus.req_cmd_in)) begin
                            cmd_q   <= bus.req_cmd_in;
                            op1_q   <= bus.req_data_in;
                            state_q <= OP2;
                        end else begin
                            resp_q  <= RESP_ERR;
                            state_q <= ERR;
                        end
                    end
                end
                OP2: begin
                    op2_q   <= bus.req_data_in;
                    cnt_q   <= CNT_LOAD;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        resp_q  <= alu_err ? RESP_ERR : RESP_OK;
                        data_q  <= alu_result;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP, ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder with a cycle-indexed expectation model checked every cycle.
module tb_calc_port_responder;

    localparam int EXEC = 2;
    localparam int MAXC = 1024;

    logic c_clk = 1'b0;
    logic reset;

    calc_port_responder_if bus ();

    calc_port_responder #(
        .EXEC_CYCLES (EXEC),
        .DATA_W      (32)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    // Expected outputs per cycle; anything never scheduled is an idle cycle with all zeros.
    logic [1:0]  expResp [MAXC];
    logic [31:0] expData [MAXC];
    bit          expBusy [MAXC];
    int          freeAt = 0;
    bit          checkEn = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearFrom(input int start);
        for (int c = start; c < MAXC; c++) begin
            expResp[c] = 2'd0;
            expData[c] = 32'd0;
            expBusy[c] = 1'b0;
        end
    endtask

    function automatic void modelCalc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        int sh;
        r = 2'd1;
        d = 32'd0;
        sh = int'(b % 32);
        case (cmd)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'hFFFF_FFFF) r = 2'd2;
                else d = s[31:0];
            end
            4'd2: begin
                if (b > a) r = 2'd2;
                else d = a - b;
            end
            4'd5: d = a << sh;
            4'd6: d = a >> sh;
            default: r = 2'd2;
        endcase
    endfunction

    // Drive one transaction (command+op1, then op2) and record what the port must answer.
    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                                 input bit waitIdle, output int tIssue);
        logic [1:0]  r;
        logic [31:0] d;
        int          rc;
        int          guard = 0;
        do begin
            @(posedge c_clk);
            #1;
            guard++;
        end while (waitIdle && cyc < freeAt && guard < 100);
        bus.req_cmd_in  = cmd;
        bus.req_data_in = d1;
        tIssue = cyc;
        if (cmd != 4'd0 && tIssue >= freeAt) begin
            if (cmd == 4'd1 || cmd == 4'd2 || cmd == 4'd5 || cmd == 4'd6) begin
                rc = tIssue + 2 + EXEC;
                modelCalc(cmd, d1, d2, r, d);
            end else begin
                rc = tIssue + 1;
                r  = 2'd2;
                d  = 32'd0;
            end
            if (rc < MAXC) begin
                for (int c = tIssue + 1; c <= rc; c++) expBusy[c] = 1'b1;
                expResp[rc] = r;
                expData[rc] = d;
            end
            freeAt = rc + 1;
        end
        @(posedge c_clk);
        #1;
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = d2;
    endtask

    task automatic checkAt(input int cycle, input logic [1:0] er, input logic [31:0] ed, input string nm);
        int guard = 0;
        @(negedge c_clk);
        while (cyc < cycle && guard < 100) begin
            @(negedge c_clk);
            guard++;
        end
        if (cyc != cycle) begin
            checkOutput({nm, "_reached"}, 32'(cyc), 32'(cycle));
        end else begin
            checkOutput({nm, "_resp"}, 32'(bus.out_resp), 32'(er));
            checkOutput({nm, "_data"}, bus.out_data, ed);
        end
    endtask

    always @(negedge c_clk) begin
        if (checkEn && cyc < MAXC) begin
            checkOutput($sformatf("out_resp@%0d", cyc), 32'(bus.out_resp), 32'(expResp[cyc]));
            checkOutput($sformatf("out_data@%0d", cyc), bus.out_data, expData[cyc]);
            checkOutput($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(expBusy[cyc]));
        end
    end

    initial begin
        int t;
        logic [1:0]  pr;
        logic [31:0] pd;

        clearFrom(0);
        reset           = 1'b0;
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;

        modelCalc(4'd1, 32'h0000_0001, 32'h01FF_FFFF, pr, pd);
        checkOutput("model_add_resp", 32'(pr), 32'd1);
        checkOutput("model_add_data", pd, 32'h0200_0000);
        modelCalc(4'd6, 32'h8000_0000, 32'h0000_0024, pr, pd);
        checkOutput("model_shr_data", pd, 32'h0800_0000);

        @(posedge c_clk);
        #1;
        checkEn = 1'b1;
        repeat (3) @(posedge c_clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_resp", 32'(bus.out_resp), 32'd0);
        checkOutput("rst_data", bus.out_data, 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);

        applyStimulus(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 1'b1, t);
        checkAt(t + 4, 2'd1, 32'h0200_0000, "add_basic");

        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, t);
        checkAt(t + 4, 2'd2, 32'h0, "add_ovf");
        applyStimulus(4'd2, 32'h0000_0001, 32'h0000_000F, 1'b1, t);
        checkAt(t + 4, 2'd2, 32'h0, "sub_udf");

        applyStimulus(4'd3, 32'h0000_0001, 32'h0, 1'b1, t);
        checkAt(t + 1, 2'd2, 32'h0, "inv_cmd3");
        applyStimulus(4'd4, 32'h0000_0001, 32'h0, 1'b1, t);
        checkAt(t + 1, 2'd2, 32'h0, "inv_cmd4");
        applyStimulus(4'd1, 32'h0, 32'h0, 1'b1, t);
        checkAt(t + 4, 2'd1, 32'h0, "add_zero");

        applyStimulus(4'd5, 32'h0000_0001, 32'h0000_001F, 1'b1, t);
        checkAt(t + 4, 2'd1, 32'h8000_0000, "shl_31");
        applyStimulus(4'd6, 32'h8000_0000, 32'h0000_0024, 1'b1, t);
        checkAt(t + 4, 2'd1, 32'h0800_0000, "shr_wrap");

        // Sub during EXEC and an add during the RESP cycle must both vanish.
        applyStimulus(4'd1, 32'h5, 32'h7, 1'b1, t);
        applyStimulus(4'd2, 32'h9, 32'h1, 1'b0, t);
        applyStimulus(4'd1, 32'h3, 32'h3, 1'b0, t);

        applyStimulus(4'd1, 32'h3, 32'h4, 1'b1, t);
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        clearFrom(cyc);
        freeAt = 0;
        #1;
        checkOutput("midrst_resp", 32'(bus.out_resp), 32'd0);
        checkOutput("midrst_data", bus.out_data, 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge c_clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(4'd1, 32'(1) << i, 32'h0, 1'b1, t);
        end

        repeat (10) @(posedge c_clk);
        #1;
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Single-port responder for the calc request protocol.
- Each transaction is two request cycles: a command plus operand1, then operand2. After a programmable execute delay the block returns a one-cycle response code and a 32-bit result.
- Serves as a standalone reference responder for port-level benches, and as the per-port engine for future multi-port calculator builds.

Parameters:
- EXEC_CYCLES, 2: cycles spent in EXEC between operand2 capture and the response; legal range 1..15.
- DATA_W, 32: operand/result width; only 32 is supported.

Ports:
- c_clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- req_cmd_in  input  [0:3]  command: 0 none, 1 add, 2 sub, 5 shift left, 6 shift right; any other value is invalid
- req_data_in  input  [0:31]  operand1 in the command cycle, operand2 in the following cycle
- out_resp  output  [0:1]  response: 0 none, 1 success, 2 invalid command / overflow / underflow, 3 never driven
- out_data  output  [0:31]  result; valid only while out_resp = 1
- busy  output  1  high from the cycle after command capture through the response cycle

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, counter = 0, operand registers = 0, out_resp = 0, out_data = 0, busy = 0.
- Reset asserted mid-transaction aborts the transaction. No response is ever issued for it.
- Bit 0 is the MSB on all buses.

FSM states: IDLE, OP2, EXEC, RESP, ERR.
- IDLE:
  - cmd = 0: stay in IDLE.
  - cmd valid: capture cmd and operand1, go to OP2.
  - cmd invalid (3, 4, 7..15): go to ERR; no operand2 cycle is consumed.
- OP2: capture req_data_in as operand2; load counter = EXEC_CYCLES-1; go to EXEC. req_cmd_in is ignored in this cycle.
- EXEC: decrement the counter each cycle. When counter = 0, register the ALU result and go to RESP.
- RESP: out_resp/out_data driven for exactly one cycle, then IDLE.
- ERR: out_resp = 2, out_data = 0 for exactly one cycle, then IDLE.
- Latency: command at cycle T gives a response at T+2+EXEC_CYCLES. An invalid command gives its response at T+1.
- Outputs are registered. out_resp = 0 and out_data = 0 in every cycle other than the response cycle.
- Commands presented while busy = 1 (including during the response cycle) are dropped with no response. The requester must wait for busy = 0.
- A command in the first cycle after RESP/ERR (back in IDLE) is accepted.

Arithmetic (ALU):
- add: 33-bit sum.
  - Carry out = 1: resp 2, data 0.
  - Otherwise: resp 1, data = sum[1:32].
- sub: operand2 > operand1 (unsigned) gives resp 2, data 0. Otherwise resp 1, data = operand1 - operand2.
- shift left/right: logical shift of operand1 by operand2[27:31] (0..31 places), zero fill. Always resp 1; bits shifted out are lost with no error.

Decomposition:
- calc_pkg holds:
  - command codes CMD_NONE/ADD/SUB/SHL/SHR;
  - response codes RESP_NONE/OK/ERR;
  - the FSM state encoding;
  - the counter width constant.
- Sub-module calc_alu: purely combinational. Inputs are cmd, op1 and op2; outputs are result[0:31] and err. The top module owns the FSM, counter and output registers.

Test Plan:
- Reset held low for 4 cycles, then released → out_resp = 0, out_data = 0, busy = 0. Assert reset low during EXEC of an add → outputs go to 0 immediately and no response follows.
- cmd 1, 0000_0001h then 01FF_FFFFh → resp 1, data 0200_0000h at exactly T+4 (EXEC_CYCLES = 2); resp is 0 in the cycles before and after.
- cmd 1, FFFF_FFFFh then 0000_0001h → resp 2, data 0. Then cmd 2, 0000_0001h then 0000_000Fh → resp 2, data 0 (underflow).
- cmd 3 with data 1 → resp 2 at T+1 and no operand2 consumed. Repeat with cmd 4 → same. Next a cmd 1, 0 + 0 → resp 1, data 0.
- cmd 5: 0000_0001h shifted by 0000_001Fh → 8000_0000h. cmd 6: 8000_0000h shifted by 0000_0024h → 0800_0000h (only the low 5 bits of the amount are used).
- Start cmd 1 (5 + 7), then present cmd 2 during EXEC → only the add response (resp 1, data 0000_000Ch) appears. Then issue back-to-back adds of x + 0 for x = 1,2,4…16384, each command given in the cycle after the previous RESP cycle → every result equals x.
